// File: rtl/apb_fsm_controller.sv
// AHB-to-APB bridge controller: one AHB transfer becomes one APB setup/access pair.
// Address, select and write data are held in registers so the APB side never sees raw AHB inputs.
module apb_fsm_controller (
    input  logic        Hclk,
    input  logic        Hreset,
    input  logic        valid,
    input  logic        Hwrite,
    input  logic [31:0] Haddr,
    input  logic [31:0] Hwdata,
    input  logic [2:0]  Temp_selx,
    input  logic [31:0] Prdata,
    output logic [2:0]  Pselx,
    output logic        Penable,
    output logic        Pwrite,
    output logic [31:0] Paddr,
    output logic [31:0] Pwdata,
    output logic        Hreadyout,
    output logic [31:0] Hrdata,
    output logic [1:0]  Hresp
);

    // state   | meaning
    // IDLE    | no transfer, ready for a request
    // WWAIT   | write address captured, waiting for the write data phase
    // READ    | APB read setup phase
    // RENABLE | APB read access phase, read data returned
    // WRITE   | APB write setup phase
    // WENABLE | APB write access phase
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WWAIT   = 3'd1,
        READ    = 3'd2,
        RENABLE = 3'd3,
        WRITE   = 3'd4,
        WENABLE = 3'd5
    } state_t;

    state_t      state_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [2:0]  sel_q;
    logic        dir_q;

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            state_q <= IDLE;
            addr_q  <= 32'h0;
            data_q  <= 32'h0;
            sel_q   <= 3'b000;
            dir_q   <= 1'b0;
        end else begin
            unique case (state_q)
                // IDLE and both access phases share the request decode, giving back-to-back transfers.
                IDLE, RENABLE, WENABLE: begin
                    if (valid) begin
                        addr_q  <= Haddr;
                        sel_q   <= Temp_selx;
                        dir_q   <= Hwrite;
                        state_q <= Hwrite ? WWAIT : READ;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                WWAIT: begin
                    data_q  <= Hwdata;
                    state_q <= WRITE;
                end
                READ:    state_q <= RENABLE;
                WRITE:   state_q <= WENABLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    logic in_read_phase;
    logic in_write_phase;

    assign in_read_phase  = (state_q == READ)  || (state_q == RENABLE);
    assign in_write_phase = (state_q == WRITE) || (state_q == WENABLE);

    assign Pselx     = (in_read_phase || in_write_phase) ? sel_q : 3'b000;
    assign Penable   = (state_q == RENABLE) || (state_q == WENABLE);
    assign Pwrite    = in_write_phase && dir_q;
    assign Paddr     = addr_q;
    assign Pwdata    = data_q;
    assign Hreadyout = (state_q == IDLE) || (state_q == RENABLE) || (state_q == WENABLE);
    assign Hrdata    = (state_q == RENABLE) ? Prdata : 32'h0;
    assign Hresp     = 2'b00;

endmodule

// File: tb/tb_apb_fsm_controller.sv
// Directed bench for apb_fsm_controller: reset, single read/write, back-to-back,
// reset mid-transfer, unselected region and idle hold, all with hand-computed expectations.
module tb_apb_fsm_controller;

    logic        Hclk = 1'b0;
    logic        Hreset;
    logic        valid;
    logic        Hwrite;
    logic [31:0] Haddr;
    logic [31:0] Hwdata;
    logic [2:0]  Temp_selx;
    logic [31:0] Prdata;
    logic [2:0]  Pselx;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic        Hreadyout;
    logic [31:0] Hrdata;
    logic [1:0]  Hresp;

    int n_checks = 0;
    int n_pass   = 0;

    apb_fsm_controller dut (
        .Hclk      (Hclk),
        .Hreset    (Hreset),
        .valid     (valid),
        .Hwrite    (Hwrite),
        .Haddr     (Haddr),
        .Hwdata    (Hwdata),
        .Temp_selx (Temp_selx),
        .Prdata    (Prdata),
        .Pselx     (Pselx),
        .Penable   (Penable),
        .Pwrite    (Pwrite),
        .Paddr     (Paddr),
        .Pwdata    (Pwdata),
        .Hreadyout (Hreadyout),
        .Hrdata    (Hrdata),
        .Hresp     (Hresp)
    );

    always #5 Hclk = ~Hclk;

    task automatic tick();
        @(posedge Hclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic req(input logic wr, input logic [31:0] a, input logic [2:0] sel);
        valid     = 1'b1;
        Hwrite    = wr;
        Haddr     = a;
        Temp_selx = sel;
    endtask

    task automatic noreq();
        valid = 1'b0;
    endtask

    initial begin
        Hreset    = 1'b1;
        valid     = 1'b0;
        Hwrite    = 1'b0;
        Haddr     = 32'h0;
        Hwdata    = 32'h0;
        Temp_selx = 3'b000;
        Prdata    = 32'hDEAD_BEEF;
        #2;
        tick();
        tick();
        check("rst_pselx",   32'(Pselx),     32'h0);
        check("rst_penable", 32'(Penable),   32'h0);
        check("rst_pwrite",  32'(Pwrite),    32'h0);
        check("rst_paddr",   Paddr,          32'h0);
        check("rst_pwdata",  Pwdata,         32'h0);
        check("rst_hready",  32'(Hreadyout), 32'h1);
        check("rst_hrdata",  Hrdata,         32'h0);
        check("rst_hresp",   32'(Hresp),     32'h0);

        // single read
        Hreset = 1'b0;
        Prdata = 32'hCAFE_F00D;
        req(1'b0, 32'h8000_0010, 3'b001);
        tick();
        noreq();
        check("rd_c1_pselx",   32'(Pselx),     32'h1);
        check("rd_c1_penable", 32'(Penable),   32'h0);
        check("rd_c1_hready",  32'(Hreadyout), 32'h0);
        check("rd_c1_paddr",   Paddr,          32'h8000_0010);
        check("rd_c1_hrdata",  Hrdata,         32'h0);
        tick();
        check("rd_c2_penable", 32'(Penable),   32'h1);
        check("rd_c2_hready",  32'(Hreadyout), 32'h1);
        check("rd_c2_hrdata",  Hrdata,         32'hCAFE_F00D);
        check("rd_c2_pwrite",  32'(Pwrite),    32'h0);
        check("rd_c2_pselx",   32'(Pselx),     32'h1);
        tick();
        check("rd_idle_pselx",  32'(Pselx),     32'h0);
        check("rd_idle_hready", 32'(Hreadyout), 32'h1);
        check("rd_idle_paddr",  Paddr,          32'h8000_0010);
        check("rd_idle_hrdata", Hrdata,         32'h0);

        // single write, data presented during WWAIT
        req(1'b1, 32'h8400_0004, 3'b010);
        tick();
        noreq();
        Hwdata = 32'h1234_5678;
        check("wr_c1_hready",  32'(Hreadyout), 32'h0);
        check("wr_c1_pselx",   32'(Pselx),     32'h0);
        check("wr_c1_penable", 32'(Penable),   32'h0);
        check("wr_c1_pwrite",  32'(Pwrite),    32'h0);
        tick();
        Hwdata = 32'hFFFF_0000;
        check("wr_c2_pselx",   32'(Pselx),     32'h2);
        check("wr_c2_pwrite",  32'(Pwrite),    32'h1);
        check("wr_c2_pwdata",  Pwdata,         32'h1234_5678);
        check("wr_c2_penable", 32'(Penable),   32'h0);
        check("wr_c2_hready",  32'(Hreadyout), 32'h0);
        check("wr_c2_paddr",   Paddr,          32'h8400_0004);
        // back-to-back write requested in WENABLE
        req(1'b1, 32'h8800_0000, 3'b100);
        tick();
        check("wr_c3_penable", 32'(Penable),   32'h1);
        check("wr_c3_hready",  32'(Hreadyout), 32'h1);
        check("wr_c3_pwdata",  Pwdata,         32'h1234_5678);
        check("wr_c3_pwrite",  32'(Pwrite),    32'h1);
        tick();
        noreq();
        Hwdata = 32'hAAAA_5555;
        check("b2b_ww_hready", 32'(Hreadyout), 32'h0);
        check("b2b_ww_paddr",  Paddr,          32'h8800_0000);
        check("b2b_ww_pselx",  32'(Pselx),     32'h0);
        tick();
        check("b2b_wr_pselx",  32'(Pselx),     32'h4);
        check("b2b_wr_pwdata", Pwdata,         32'hAAAA_5555);
        req(1'b0, 32'h8000_0000, 3'b001);
        tick();
        check("b2b_we_penable", 32'(Penable),  32'h1);
        tick();
        noreq();
        check("b2b_rd_paddr",   Paddr,          32'h8000_0000);
        check("b2b_rd_pselx",   32'(Pselx),     32'h1);
        check("b2b_rd_hready",  32'(Hreadyout), 32'h0);
        check("b2b_rd_penable", 32'(Penable),   32'h0);
        check("b2b_rd_pwrite",  32'(Pwrite),    32'h0);
        tick();
        check("b2b_re_hrdata", Hrdata,         32'hCAFE_F00D);
        tick();
        check("b2b_idle_hready", 32'(Hreadyout), 32'h1);

        // reset asserted in WRITE, with a request at the reset edge
        req(1'b1, 32'h8400_0008, 3'b010);
        tick();
        noreq();
        Hwdata = 32'h5A5A_5A5A;
        tick();
        check("rstw_pwrite", 32'(Pwrite), 32'h1);
        Hreset = 1'b1;
        req(1'b0, 32'h8000_0020, 3'b001);
        tick();
        Hreset = 1'b0;
        noreq();
        check("rstw_pselx",   32'(Pselx),     32'h0);
        check("rstw_penable", 32'(Penable),   32'h0);
        check("rstw_paddr",   Paddr,          32'h0);
        check("rstw_pwdata",  Pwdata,         32'h0);
        check("rstw_hready",  32'(Hreadyout), 32'h1);
        tick();
        check("rstw_after_penable", 32'(Penable),   32'h0);
        check("rstw_after_pselx",   32'(Pselx),     32'h0);
        check("rstw_after_hready",  32'(Hreadyout), 32'h1);

        // unselected region still runs the full read sequence
        Prdata = 32'h0BAD_C0DE;
        req(1'b0, 32'h8C00_0000, 3'b000);
        tick();
        noreq();
        check("nosel_c1_pselx",  32'(Pselx),     32'h0);
        check("nosel_c1_hready", 32'(Hreadyout), 32'h0);
        check("nosel_c1_paddr",  Paddr,          32'h8C00_0000);
        tick();
        check("nosel_c2_pselx",   32'(Pselx),     32'h0);
        check("nosel_c2_penable", 32'(Penable),   32'h1);
        check("nosel_c2_hready",  32'(Hreadyout), 32'h1);
        check("nosel_c2_hrdata",  Hrdata,         32'h0BAD_C0DE);

        // idle hold
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_pselx",   32'(Pselx),     32'h0);
            check("idle_penable", 32'(Penable),   32'h0);
            check("idle_hready",  32'(Hreadyout), 32'h1);
        end
        check("final_hresp", 32'(Hresp), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/apb_fsm_controller.md
APB_FSM_CONTROLLER -- requirements
Module: apb_fsm_controller

Interface
REQ-001 Hclk  input  1  single clock; all state changes on the rising edge.
REQ-002 Hreset  input  1  synchronous, active-high reset, sampled on the rising edge of Hclk.
REQ-003 valid  input  1  qualified AHB transfer request for the current address phase.
REQ-004 Hwrite  input  1  direction of the current address phase: 1 = write.
REQ-005 Haddr  input  32  AHB address for the current address phase.
REQ-006 Hwdata  input  32  AHB write data, valid during the write data phase.
REQ-007 Temp_selx  input  3  one-hot peripheral select decoded from Haddr.
REQ-008 Prdata  input  32  APB read data from the selected peripheral.
REQ-009 Pselx  output  3  APB peripheral selects.
REQ-010 Penable  output  1  APB enable (access phase).
REQ-011 Pwrite  output  1  APB direction.
REQ-012 Paddr  output  32  APB address.
REQ-013 Pwdata  output  32  APB write data.
REQ-014 Hreadyout  output  1  AHB ready returned to the master.
REQ-015 Hrdata  output  32  AHB read data.
REQ-016 Hresp  output  2  AHB response; constant 2'b00 (OKAY).

Function
REQ-017 The FSM SHALL have six states: IDLE, WWAIT, READ, RENABLE, WRITE, WENABLE.
REQ-018 Transitions out of IDLE, RENABLE and WENABLE SHALL be identical:
- valid=1 and Hwrite=0 -> READ.
- valid=1 and Hwrite=1 -> WWAIT.
- otherwise -> IDLE.
REQ-019 The remaining states SHALL advance unconditionally: WWAIT->WRITE, WRITE->WENABLE, READ->RENABLE.
REQ-020 On every transition into READ or WWAIT, the block SHALL register Haddr into addr_reg, Temp_selx into sel_reg and Hwrite into dir_reg.
REQ-021 On the transition WWAIT->WRITE, the block SHALL register Hwdata into data_reg.
REQ-022 Hreadyout SHALL be 1 in IDLE, RENABLE and WENABLE, and 0 in WWAIT, READ and WRITE.
REQ-023 Pselx SHALL equal sel_reg in READ, RENABLE, WRITE and WENABLE, and 3'b000 in all other states.
REQ-024 Penable SHALL be 1 only in RENABLE and WENABLE.
REQ-025 Pwrite SHALL be 1 only in WRITE and WENABLE.
REQ-026 Paddr SHALL always equal addr_reg.
REQ-027 Pwdata SHALL always equal data_reg.
REQ-028 All P* outputs and Hreadyout SHALL be decoded from registered state and registers only, with no combinational path from any input.
REQ-029 Hrdata SHALL equal Prdata in RENABLE and 32'h0 in all other states.
REQ-030 Latency SHALL be fixed:
- read: 2 cycles from the IDLE sample to Hreadyout=1 with data.
- write: 3 cycles from the IDLE sample to Hreadyout=1.
REQ-031 Back-to-back transfers: a valid request sampled in RENABLE or WENABLE SHALL start the next transfer with no IDLE cycle in between.
REQ-032 A valid request with Temp_selx=3'b000 (address region 8'h8C) SHALL still run the full APB sequence with Pselx=3'b000; a read in this case returns whatever Prdata carries.
REQ-033 Inputs SHALL be ignored in WWAIT, READ and WRITE. The master holds the address and data stable while Hreadyout=0.

Reset
REQ-034 While Hreset=1 at a rising edge, the block SHALL:
- set the state to IDLE;
- clear addr_reg, data_reg, sel_reg and dir_reg to 0;
- produce outputs from the next cycle: Pselx=000, Penable=0, Pwrite=0, Paddr=0, Pwdata=0, Hreadyout=1, Hrdata=0, Hresp=00.
REQ-035 A reset asserted in any state SHALL abort the transfer at the next edge with no further Penable pulse. The transfer is not completed after reset is released.
REQ-036 A valid request sampled in the same edge as Hreset=1 SHALL be discarded.

Verification
REQ-037 Single read, Haddr=32'h8000_0010, Temp_selx=001, Prdata=32'hCAFE_F00D:
- cycle 1: READ, Pselx=001, Penable=0, Hreadyout=0.
- cycle 2: RENABLE, Penable=1, Hreadyout=1, Hrdata=32'hCAFE_F00D.
REQ-038 Single write, Haddr=32'h8400_0004, Temp_selx=010, Hwdata=32'h1234_5678 during WWAIT:
- cycle 1: WWAIT, Hreadyout=0.
- cycle 2: WRITE, Pselx=010, Pwrite=1, Pwdata=32'h1234_5678.
- cycle 3: WENABLE, Penable=1, Hreadyout=1.
REQ-039 Write to 32'h8800_0000 followed immediately by a read of 32'h8000_0000 sampled in WENABLE: the next cycle is READ with Paddr=32'h8000_0000 and Pselx=001, with no IDLE cycle in between.
REQ-040 Hreset=1 asserted in WRITE: the next cycle is IDLE with Pselx=000, Penable=0, Paddr=0 and Hreadyout=1, and no access phase occurs.
REQ-041 valid=1 with Haddr=32'h8C00_0000 and Temp_selx=000 (read): the READ and RENABLE sequence executes with Pselx=000 throughout and Hreadyout=1 in RENABLE.
REQ-042 valid=0 held for 10 cycles: the block stays in IDLE with Pselx=000, Penable=0 and Hreadyout=1 throughout.
